// File: rtl/line_writeback.sv
// Cache line writeback: arbitrates for the system bus, sends a WRITE
// address beat, then streams BEATS data beats of the latched line.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   enable, addr, data  start request, line byte address, line payload
//   abtr_grant          arbiter grant      -> abtr_reqcyc, bus_busy
//   main_bus_reqack     address accepted   -> main_bus_reqcyc/req/reqtag
//   done                line fully sent, held until the next enable
module line_writeback #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int BEATS = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG = 13'h1100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [BUS_DATA_WIDTH-1:0]   addr,
  input  logic [BUS_DATA_WIDTH*BEATS-1:0] data,
  input  logic                        abtr_grant,
  output logic                        abtr_reqcyc,
  output logic                        bus_busy,
  output logic                        main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    main_bus_reqtag,
  input  logic                        main_bus_reqack,
  output logic                        done
);

  localparam int W  = BUS_DATA_WIDTH;
  localparam int LW = BUS_DATA_WIDTH * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [W-1:0]    laddr, laddr_n;
  logic [LW-1:0]   ldata, ldata_n;

  logic            abtr_n, busy_n, cyc_n, done_n;
  logic [W-1:0]    req_n;
  logic [BUS_TAG_WIDTH-1:0] tag_n;

  assign cnt_inc = cnt + CW'(1);

  // Outputs are computed for the next state and registered with it,
  // so every bus signal comes straight from a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    laddr_n = laddr;
    ldata_n = ldata;
    abtr_n  = 1'b0;
    busy_n  = 1'b0;
    cyc_n   = 1'b0;
    req_n   = '0;
    tag_n   = '0;
    done_n  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        cnt_n = '0;
        if (enable) begin
          laddr_n = {addr[W-1:6], 6'b0};
          ldata_n = data;
          state_n = ARB;
          abtr_n  = 1'b1;
        end else begin
          done_n = (state == DONE);
        end
      end
      ARB: begin
        abtr_n = 1'b1;
        if (abtr_grant) begin
          state_n = ADDR;
          busy_n  = 1'b1;
          cyc_n   = 1'b1;
          req_n   = laddr;
          tag_n   = WRITE_TAG;
        end
      end
      ADDR: begin
        abtr_n = 1'b1;
        busy_n = 1'b1;
        cyc_n  = 1'b1;
        tag_n  = WRITE_TAG;
        if (main_bus_reqack) begin
          state_n = DATA;
          cnt_n   = '0;
          req_n   = ldata[0 +: W];
        end else begin
          req_n = laddr;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          state_n = DONE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          abtr_n = 1'b1;
          busy_n = 1'b1;
          cyc_n  = 1'b1;
          tag_n  = WRITE_TAG;
          cnt_n  = cnt_inc;
          req_n  = ldata[int'(cnt_inc)*W +: W];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      laddr           <= '0;
      ldata           <= '0;
      abtr_reqcyc     <= 1'b0;
      bus_busy        <= 1'b0;
      main_bus_reqcyc <= 1'b0;
      main_bus_req    <= '0;
      main_bus_reqtag <= '0;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      laddr           <= laddr_n;
      ldata           <= ldata_n;
      abtr_reqcyc     <= abtr_n;
      bus_busy        <= busy_n;
      main_bus_reqcyc <= cyc_n;
      main_bus_req    <= req_n;
      main_bus_reqtag <= tag_n;
      done            <= done_n;
    end
  end

endmodule

// File: tb/tb_line_writeback.sv
// Bench for line_writeback: vector table, directed corner sequences
// and random traffic against a transaction-level reference model.
module tb_line_writeback;

  localparam int BEATS = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [63:0]  addr = '0;
  logic [511:0] data = '0;
  logic         abtr_grant = 1'b0;
  logic         main_bus_reqack = 1'b0;
  logic         abtr_reqcyc, bus_busy, main_bus_reqcyc, done;
  logic [63:0]  main_bus_req;
  logic [12:0]  main_bus_reqtag;

  int checks = 0;
  int failures = 0;

  line_writeback dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .addr(addr),
    .data(data),
    .abtr_grant(abtr_grant),
    .abtr_reqcyc(abtr_reqcyc),
    .bus_busy(bus_busy),
    .main_bus_reqcyc(main_bus_reqcyc),
    .main_bus_req(main_bus_req),
    .main_bus_reqtag(main_bus_reqtag),
    .main_bus_reqack(main_bus_reqack),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: one line transfer tracked as flags + beat index.
  bit           m_active, m_granted, m_acked, m_done;
  int           m_beat;
  logic [63:0]  m_addr;
  logic [511:0] m_data;

  task automatic model_reset();
    m_active = 0; m_granted = 0; m_acked = 0; m_done = 0;
    m_beat = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    if (!m_active) begin
      if (enable) begin
        m_addr = {addr[63:6], 6'b0};
        m_data = data;
        m_active = 1; m_granted = 0; m_acked = 0;
        m_beat = 0; m_done = 0;
      end
    end else if (!m_granted) begin
      m_granted = abtr_grant;
    end else if (!m_acked) begin
      if (main_bus_reqack) begin
        m_acked = 1;
        m_beat = 0;
      end
    end else if (m_beat == BEATS - 1) begin
      m_active = 0;
      m_done = 1;
    end else begin
      m_beat++;
    end
  endtask

  function automatic logic [80:0] model_out();
    logic        own;
    logic [63:0] req;
    own = m_active && m_granted;
    req = !own ? 64'h0 : !m_acked ? m_addr : m_data[m_beat*64 +: 64];
    return {m_active, own, own, req, own ? 13'h1100 : 13'h0,
            m_done && !m_active};
  endfunction

  function automatic logic [80:0] dut_out();
    return {abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req,
            main_bus_reqtag, done};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input string nm);
    logic [80:0] g, e;
    @(posedge clk);
    model_edge();
    #1;
    g = dut_out();
    e = model_out();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, g, e);
    end
  endtask

  task automatic rand_line();
    for (int k = 0; k < 16; k++) data[k*32 +: 32] = $urandom;
  endtask

  typedef struct {
    logic        en, gnt, ack;
    logic        abtr, busy, cyc;
    logic [63:0] req;
    logic        dn;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(logic en, logic gnt, logic ack, logic abtr,
                              logic busy, logic cyc, logic [63:0] req,
                              logic dn);
    vec_t v;
    v.en = en; v.gnt = gnt; v.ack = ack; v.abtr = abtr;
    v.busy = busy; v.cyc = cyc; v.req = req; v.dn = dn;
    return v;
  endfunction

  initial begin
    int n, na, nd;
    logic [63:0] bk;

    tv[0] = mk(1, 1, 1, 1, 0, 0, 64'h0, 0);
    tv[1] = mk(0, 1, 1, 1, 1, 1, 64'h1000_0040, 0);
    for (int k = 0; k < 8; k++) begin
      bk = 64'hA5A5_0000_0000_0000 | 64'(k);
      tv[2+k] = mk(0, 1, 1, 1, 1, 1, bk, 0);
    end
    tv[10] = mk(0, 1, 1, 0, 0, 0, 64'h0, 1);
    tv[11] = mk(0, 1, 1, 0, 0, 0, 64'h0, 1);

    model_reset();
    @(posedge clk);
    #1;
    chk("reset_outputs", 64'(dut_out()), 64'h0);
    chk("reset_tag_done", {51'h0, main_bus_reqtag}, 64'h0);
    #3 reset = 1'b1;

    // Basic write, table driven
    addr = 64'h1000_0047;
    for (int k = 0; k < 8; k++)
      data[k*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(k);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      enable = tv[i].en;
      abtr_grant = tv[i].gnt;
      main_bus_reqack = tv[i].ack;
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if ({abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req,
           main_bus_reqtag, done} !==
          {tv[i].abtr, tv[i].busy, tv[i].cyc, tv[i].req,
           tv[i].cyc ? 13'h1100 : 13'h0, tv[i].dn}) begin
        failures++;
        $display("FAIL vec%0d got=%h req=%h exp_req=%h", i,
                 dut_out(), main_bus_req, tv[i].req);
      end
    end

    // Delayed grant: 5 cycles of waiting in arbitration
    addr = 64'h5555_0100; rand_line();
    enable = 1; abtr_grant = 0; main_bus_reqack = 1;
    step("dg_start"); n = 1;
    enable = 0;
    repeat (5) begin step("dg_wait"); n++; end
    abtr_grant = 1;
    for (int i = 0; i < 40 && !done; i++) begin step("dg_run"); n++; end
    chk("dg_latency", 64'(n), 64'd16);

    // Delayed ack: address beat held 4 cycles
    addr = 64'h3000_0005; rand_line();
    enable = 1; abtr_grant = 1; main_bus_reqack = 0;
    step("da_start");
    enable = 0;
    na = 0; nd = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 4) main_bus_reqack = 1;
      step("da_run");
      if (main_bus_reqcyc && main_bus_req == 64'h3000_0000) na++;
      else if (main_bus_reqcyc) nd++;
    end
    chk("da_addr_cycles", 64'(na), 64'd4);
    chk("da_data_beats", 64'(nd), 64'd8);
    chk("da_done", 64'(done), 64'd1);

    // Enable and new line while streaming beat 3
    addr = 64'h4000_0000; rand_line();
    enable = 1;
    step("eb_start");
    enable = 0;
    repeat (5) step("eb_run");
    chk("eb_at_beat3", 64'(main_bus_req), m_data[3*64 +: 64]);
    enable = 1; addr = 64'h7777_0000; rand_line();
    step("eb_beat4");
    enable = 0;
    for (int i = 0; i < 20 && !done; i++) step("eb_run");
    repeat (3) step("eb_idle");
    chk("eb_no_second", 64'({abtr_reqcyc, done}), 64'b01);

    // Reset mid-data at beat 5
    addr = 64'h6000_0000; rand_line();
    enable = 1;
    step("rs_start");
    enable = 0;
    repeat (7) step("rs_run");
    chk("rs_at_beat5", 64'(main_bus_req), m_data[5*64 +: 64]);
    #2 reset = 1'b0;
    #1;
    chk("rs_async_out", 64'(dut_out()), 64'h0);
    chk("rs_async_hi", 64'(dut_out() >> 64), 64'h0);
    model_reset();
    #2 reset = 1'b1;
    repeat (4) step("rs_quiet");

    // Back-to-back from done
    addr = 64'h1234_0000; rand_line();
    enable = 1;
    step("bb_first");
    enable = 0;
    for (int i = 0; i < 20 && !done; i++) step("bb_run");
    chk("bb_done1", 64'(done), 64'd1);
    enable = 1; addr = 64'h2000; rand_line();
    step("bb_second");
    chk("bb_done_drop", 64'({done, abtr_reqcyc}), 64'b01);
    enable = 0;
    step("bb_addr");
    chk("bb_req_addr", main_bus_req, 64'h2000);
    for (int i = 0; i < 20 && !done; i++) step("bb_run2");
    chk("bb_done2", 64'(done), 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 3) == 0);
      abtr_grant = $urandom_range(0, 1) != 0;
      main_bus_reqack = $urandom_range(0, 1) != 0;
      addr = {$urandom, $urandom};
      rand_line();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
